// File: rtl/flash_prog_seq_if.sv
// flash_prog_seq_if
//  Bundles the requester-side handshake and the SPI flash engine command bus of flash_prog_seq.
//  slave  : sequencer side (flash_prog_seq)
//  master : requester + engine side (user logic / testbench)
//  Requester : req_valid, req_ready, req_op[1:0], req_addr[23:0], req_wdata[7:0],
//              rsp_valid, rsp_data[7:0], rsp_err[1:0], busy
//  Engine    : cmd_type[3:0], flash_cmd[7:0], flash_addr[23:0], wrdata[7:0],
//              Done_Sig, mydata_o[7:0], myvalid_o
interface flash_prog_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [23:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_err;
   logic        busy;
   logic [3:0]  cmd_type;
   logic [7:0]  flash_cmd;
   logic [23:0] flash_addr;
   logic [7:0]  wrdata;
   logic        Done_Sig;
   logic [7:0]  mydata_o;
   logic        myvalid_o;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, Done_Sig, mydata_o, myvalid_o,
      output req_ready, rsp_valid, rsp_data, rsp_err, busy,
             cmd_type, flash_cmd, flash_addr, wrdata
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, Done_Sig, mydata_o, myvalid_o,
      input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
             cmd_type, flash_cmd, flash_addr, wrdata
   );
endinterface

// File: rtl/flash_prog_seq.sv
// flash_prog_seq
//  Expands byte-level READ / SECTOR ERASE / BYTE PROGRAM requests into SPI flash engine command
//  chains (WREN, op, RDSR polling) and returns one response per request.
//  Ports:
//   CLK  in  system clock
//   RST  in  synchronous reset, active-high
//   bus  flash_prog_seq_if.slave (requester handshake + engine command bus)
//  Parameters:
//   POLL_MAX  RDSR polls before a timeout response (16-bit compare)
//   CMD_GAP   idle cycles between consecutive engine commands (>= 1)
//  Optional feature: define FLASH_VERIFY_EN to read back and compare the byte after PROGRAM.
//
//  state  | meaning
//  IDLE   | ready for a request
//  CMD    | engine command driven, waiting for Done_Sig
//  GAP    | cmd_type=0 for CMD_GAP cycles, then pick next command or respond
//  RESP   | one-cycle response pulse
module flash_prog_seq #(
   parameter int POLL_MAX = 65535,
   parameter int CMD_GAP  = 4
) (
   input  logic            CLK,
   input  logic            RST,
   flash_prog_seq_if.slave bus
);

   localparam int GW = (CMD_GAP < 2) ? 1 : $clog2(CMD_GAP);

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_ERASE = 2'd1;
   localparam logic [1:0] OP_PROG  = 2'd2;

   localparam logic [3:0] T_CMD  = 4'h8;
   localparam logic [3:0] T_CMDR = 4'h9;
   localparam logic [3:0] T_ADDR = 4'hA;
   localparam logic [3:0] T_RD   = 4'hB;
   localparam logic [3:0] T_WR   = 4'hC;

   localparam logic [7:0] C_READ = 8'h03;
   localparam logic [7:0] C_WREN = 8'h06;
   localparam logic [7:0] C_SE   = 8'h20;
   localparam logic [7:0] C_PP   = 8'h02;
   localparam logic [7:0] C_RDSR = 8'h05;

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_GAP, S_RESP} state_t;

   // Which command of the chain is (or was last) in flight.
   typedef enum logic [2:0] {
      PH_RD, PH_WREN, PH_OP, PH_POLL
`ifdef FLASH_VERIFY_EN
      , PH_VFY
`endif
   } ph_t;

   state_t      state_q, state_d;
   ph_t         ph_q, ph_d;
   logic [1:0]  op_q, op_d;
   logic [23:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  byte_q, byte_d;
   logic [15:0] poll_q, poll_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [3:0]  cmd_type_q, cmd_type_d;
   logic [7:0]  flash_cmd_q, flash_cmd_d;
   logic [23:0] flash_addr_q, flash_addr_d;
   logic [7:0]  eng_wr_q, eng_wr_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic [1:0]  rsp_err_q, rsp_err_d;

   logic        go;
   logic [3:0]  go_type;
   logic [7:0]  go_cmd;
   logic [23:0] go_addr;
   logic [7:0]  go_wr;
   logic [15:0] poll_inc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         ph_q         <= PH_RD;
         op_q         <= 2'd0;
         addr_q       <= 24'd0;
         wdata_q      <= 8'd0;
         byte_q       <= 8'd0;
         poll_q       <= 16'd0;
         gap_q        <= '0;
         cmd_type_q   <= 4'h0;
         flash_cmd_q  <= 8'h00;
         flash_addr_q <= 24'd0;
         eng_wr_q     <= 8'h00;
         rsp_data_q   <= 8'h00;
         rsp_err_q    <= 2'd0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         byte_q       <= byte_d;
         poll_q       <= poll_d;
         gap_q        <= gap_d;
         cmd_type_q   <= cmd_type_d;
         flash_cmd_q  <= flash_cmd_d;
         flash_addr_q <= flash_addr_d;
         eng_wr_q     <= eng_wr_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      byte_d       = byte_q;
      poll_d       = poll_q;
      gap_d        = gap_q;
      cmd_type_d   = cmd_type_q;
      flash_cmd_d  = flash_cmd_q;
      flash_addr_d = flash_addr_q;
      eng_wr_d     = eng_wr_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      go           = 1'b0;
      go_type      = 4'h0;
      go_cmd       = 8'h00;
      go_addr      = 24'd0;
      go_wr        = 8'h00;
      poll_inc     = poll_q + 16'd1;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               poll_d  = 16'd0;
               case (bus.req_op)
                  OP_READ: begin
                     go = 1'b1; go_type = T_RD; go_cmd = C_READ; go_addr = bus.req_addr;
                     ph_d = PH_RD;
                  end
                  OP_ERASE, OP_PROG: begin
                     go = 1'b1; go_type = T_CMD; go_cmd = C_WREN;
                     ph_d = PH_WREN;
                  end
                  default: begin
                     state_d   = S_RESP;
                     rsp_err_d = 2'd3;
                  end
               endcase
            end
         end

         S_CMD: begin
            if (bus.myvalid_o && (cmd_type_q == T_RD || cmd_type_q == T_CMDR))
               byte_d = bus.mydata_o;
            if (bus.Done_Sig) begin
               cmd_type_d = 4'h0;
               gap_d      = GW'(CMD_GAP - 1);
               state_d    = S_GAP;
            end
         end

         S_GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end else begin
               case (ph_q)
                  PH_RD: begin
                     state_d = S_RESP; rsp_data_d = byte_q; rsp_err_d = 2'd0;
                  end
                  PH_WREN: begin
                     go = 1'b1; go_addr = addr_q; ph_d = PH_OP;
                     if (op_q == OP_ERASE) begin
                        go_type = T_ADDR; go_cmd = C_SE;
                     end else begin
                        go_type = T_WR; go_cmd = C_PP; go_wr = wdata_q;
                     end
                  end
                  PH_OP: begin
                     go = 1'b1; go_type = T_CMDR; go_cmd = C_RDSR; ph_d = PH_POLL;
                  end
                  PH_POLL: begin
                     if (!byte_q[0]) begin
`ifdef FLASH_VERIFY_EN
                        if (op_q == OP_PROG) begin
                           go = 1'b1; go_type = T_RD; go_cmd = C_READ; go_addr = addr_q;
                           ph_d = PH_VFY;
                        end else begin
                           state_d = S_RESP; rsp_data_d = byte_q; rsp_err_d = 2'd0;
                        end
`else
                        state_d = S_RESP; rsp_data_d = byte_q; rsp_err_d = 2'd0;
`endif
                     end else begin
                        // Compare after increment so at least one RDSR result is always seen.
                        poll_d = poll_inc;
                        if (poll_inc == 16'(POLL_MAX)) begin
                           state_d = S_RESP; rsp_data_d = byte_q; rsp_err_d = 2'd1;
                        end else begin
                           go = 1'b1; go_type = T_CMDR; go_cmd = C_RDSR;
                        end
                     end
                  end
`ifdef FLASH_VERIFY_EN
                  PH_VFY: begin
                     state_d    = S_RESP;
                     rsp_data_d = byte_q;
                     rsp_err_d  = (byte_q != wdata_q) ? 2'd2 : 2'd0;
                  end
`endif
                  default: state_d = S_IDLE;
               endcase
            end
         end

         S_RESP: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase

      if (go) begin
         state_d      = S_CMD;
         cmd_type_d   = go_type;
         flash_cmd_d  = go_cmd;
         flash_addr_d = go_addr;
         eng_wr_d     = go_wr;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.cmd_type   = cmd_type_q;
   assign bus.flash_cmd  = flash_cmd_q;
   assign bus.flash_addr = flash_addr_q;
   assign bus.wrdata     = eng_wr_q;

endmodule

// File: tb/tb_flash_prog_seq.sv
`timescale 1ns/1ps
module tb_flash_prog_seq;
   localparam int POLL_MAX = 3;
   localparam int CMD_GAP  = 4;

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   flash_prog_seq_if ifc();

   flash_prog_seq #(.POLL_MAX(POLL_MAX), .CMD_GAP(CMD_GAP)) dut (
      .CLK(clk), .RST(rst), .bus(ifc)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rsp_cnt = 0;
   always @(negedge clk) if (ifc.rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

   // Engine model controls (written by main only)
   logic        eng_stall;
   int          spur_n;
   int          stat_base;
   logic [31:0] stat_w;
   logic [7:0]  rd_val;
   // Engine model state (written by engine only)
   int          n_cmds;
   int          rdsr_total;
   int          spur_seen;
   int          hold_bad;
   logic [3:0]  log_type [128];
   logic [7:0]  log_cmd  [128];
   logic [23:0] log_addr [128];
   logic [7:0]  log_wr   [128];
   int          log_start[128];
   int          log_done [128];

   initial begin
      logic [3:0]  t;
      logic [7:0]  c;
      logic [23:0] a;
      logic [7:0]  w;
      int          idx, k;
      ifc.Done_Sig = 1'b0; ifc.myvalid_o = 1'b0; ifc.mydata_o = 8'h00;
      n_cmds = 0; rdsr_total = 0; spur_seen = 0; hold_bad = 0;
      forever begin
         @(negedge clk);
         if (spur_n != spur_seen) begin
            spur_seen++;
            ifc.Done_Sig = 1'b1;
            @(negedge clk);
            ifc.Done_Sig = 1'b0;
         end else if (ifc.cmd_type != 4'h0) begin
            t = ifc.cmd_type; c = ifc.flash_cmd; a = ifc.flash_addr; w = ifc.wrdata;
            idx = n_cmds % 128;
            log_type[idx] = t; log_cmd[idx] = c; log_addr[idx] = a; log_wr[idx] = w;
            log_start[idx] = cyc; log_done[idx] = -1;
            n_cmds++;
            repeat (2) begin
               @(negedge clk);
               if (ifc.cmd_type !== t || ifc.flash_cmd !== c || ifc.flash_addr !== a ||
                   ifc.wrdata !== w) hold_bad++;
            end
            while (eng_stall && t == 4'hC) @(negedge clk);
            if (ifc.cmd_type != 4'h0) begin
               if (t == 4'h9) begin
                  k = rdsr_total - stat_base;
                  if (k > 3) k = 3;
                  ifc.mydata_o = stat_w[k*8 +: 8];
                  ifc.myvalid_o = 1'b1;
                  rdsr_total++;
               end else if (t == 4'hB) begin
                  ifc.mydata_o = rd_val;
                  ifc.myvalid_o = 1'b1;
               end
               ifc.Done_Sig = 1'b1;
               log_done[idx] = cyc;
               @(negedge clk);
               ifc.Done_Sig = 1'b0;
               ifc.myvalid_o = 1'b0;
            end
         end
      end
   end

   task automatic do_req(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd,
                         output logic [7:0] d, output logic [1:0] e, output int lat,
                         output int rcyc, output bit seen, output bit one);
      int w;
      w = 0;
      while (ifc.req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_addr = addr; ifc.req_wdata = wd;
      @(negedge clk);
      // Later req_* changes must be ignored
      ifc.req_valid = 1'b0; ifc.req_op = op + 2'd1; ifc.req_addr = ~addr; ifc.req_wdata = ~wd;
      lat = 0;
      while (ifc.rsp_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
      seen = (ifc.rsp_valid === 1'b1);
      d = ifc.rsp_data; e = ifc.rsp_err; rcyc = cyc;
      @(negedge clk);
      one = (ifc.rsp_valid === 1'b0) && (ifc.req_ready === 1'b1);
   endtask

   typedef struct packed {
      logic [1:0]  op;
      logic [23:0] addr;
      logic [7:0]  wd;
      logic [7:0]  rdv;
      logic [31:0] st;
      logic [7:0]  exp_d;
      logic [1:0]  exp_e;
      int          exp_n;
      logic [7:0]  exp_last;
   } vec_t;

   function automatic vec_t mk(logic [1:0] op, logic [23:0] addr, logic [7:0] wd, logic [7:0] rdv,
                               logic [31:0] st, logic [7:0] exp_d, logic [1:0] exp_e, int exp_n,
                               logic [7:0] exp_last);
      vec_t v;
      v.op = op; v.addr = addr; v.wd = wd; v.rdv = rdv; v.st = st;
      v.exp_d = exp_d; v.exp_e = exp_e; v.exp_n = exp_n; v.exp_last = exp_last;
      return v;
   endfunction

   vec_t vecs[8];

   initial begin
      logic [7:0] d;
      logic [1:0] e;
      int lat, rcyc, n0, r0, w;
      bit seen, one;
      logic [3:0] exp_t [6];
      logic [7:0] exp_c [6];

      rst = 1'b1;
      ifc.req_valid = 1'b0; ifc.req_op = 2'd0; ifc.req_addr = 24'd0; ifc.req_wdata = 8'd0;
      eng_stall = 1'b0; spur_n = 0; stat_base = 0; stat_w = 32'd0; rd_val = 8'd0;

      // st packs the RDSR sequence, first status in [7:0]
      vecs[0] = mk(2'd0, 24'h012345, 8'h00, 8'hA5, 32'h0,        8'hA5, 2'd0, 1, 8'h03);
`ifdef FLASH_VERIFY_EN
      vecs[1] = mk(2'd2, 24'h000100, 8'h3C, 8'h3C, 32'h00000303, 8'h3C, 2'd0, 6, 8'h03);
`else
      vecs[1] = mk(2'd2, 24'h000100, 8'h3C, 8'h3C, 32'h00000303, 8'h00, 2'd0, 5, 8'h05);
`endif
      vecs[2] = mk(2'd1, 24'h000FFF, 8'h00, 8'h00, 32'h01010101, 8'h01, 2'd1, 5, 8'h05);
      vecs[3] = mk(2'd3, 24'h123456, 8'h77, 8'h00, 32'h0,        8'h01, 2'd3, 0, 8'h00);
      vecs[4] = mk(2'd1, 24'h0ABCDE, 8'h00, 8'h00, 32'h00000001, 8'h00, 2'd0, 4, 8'h05);
`ifdef FLASH_VERIFY_EN
      vecs[5] = mk(2'd2, 24'hFFFFFF, 8'h5A, 8'h58, 32'h0,        8'h58, 2'd2, 4, 8'h03);
`else
      vecs[5] = mk(2'd2, 24'hFFFFFF, 8'h5A, 8'h58, 32'h0,        8'h00, 2'd0, 3, 8'h05);
`endif
      vecs[6] = mk(2'd0, 24'hFFFFFF, 8'h00, 8'h00, 32'h0,        8'h00, 2'd0, 1, 8'h03);
      vecs[7] = mk(2'd2, 24'h00ABCD, 8'h11, 8'h11, 32'h01010101, 8'h01, 2'd1, 5, 8'h05);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset req_ready", 32'(ifc.req_ready), 32'd1);
      chk("reset busy", 32'(ifc.busy), 32'd0);
      chk("reset rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("reset rsp_data", 32'(ifc.rsp_data), 32'd0);
      chk("reset rsp_err", 32'(ifc.rsp_err), 32'd0);
      chk("reset cmd_type", 32'(ifc.cmd_type), 32'd0);
      chk("reset flash_cmd", 32'(ifc.flash_cmd), 32'd0);
      chk("reset flash_addr", 32'(ifc.flash_addr), 32'd0);
      chk("reset wrdata", 32'(ifc.wrdata), 32'd0);

      // Done_Sig while idle must be ignored
      n0 = n_cmds; r0 = rsp_cnt;
      spur_n++;
      repeat (4) @(negedge clk);
      chk("spurious done busy", 32'(ifc.busy), 32'd0);
      chk("spurious done rsp", 32'(rsp_cnt - r0), 32'd0);

      for (int i = 0; i < 8; i++) begin
         stat_base = rdsr_total; stat_w = vecs[i].st; rd_val = vecs[i].rdv;
         n0 = n_cmds;
         do_req(vecs[i].op, vecs[i].addr, vecs[i].wd, d, e, lat, rcyc, seen, one);
         chk($sformatf("v%0d rsp_seen", i), 32'(seen), 32'd1);
         chk($sformatf("v%0d rsp_data", i), 32'(d), 32'(vecs[i].exp_d));
         chk($sformatf("v%0d rsp_err", i), 32'(e), 32'(vecs[i].exp_e));
         chk($sformatf("v%0d n_cmds", i), 32'(n_cmds - n0), 32'(vecs[i].exp_n));
         chk($sformatf("v%0d rsp_one_cycle", i), 32'(one), 32'd1);
         if (vecs[i].exp_n > 0)
            chk($sformatf("v%0d last_cmd", i), 32'(log_cmd[(n_cmds - 1) % 128]),
                32'(vecs[i].exp_last));
         else
            chk($sformatf("v%0d illegal latency", i), 32'(lat), 32'd0);
         if (vecs[i].op == 2'd0) begin
            chk($sformatf("v%0d rd type", i), 32'(log_type[n0 % 128]), 32'hB);
            chk($sformatf("v%0d rd addr", i), 32'(log_addr[n0 % 128]), 32'(vecs[i].addr));
            chk($sformatf("v%0d rd latency", i), 32'(rcyc - log_done[n0 % 128]), 32'(CMD_GAP + 1));
         end
      end

      // Full PROGRAM chain: opcodes, types, payload and command spacing
      exp_t[0] = 4'h8; exp_t[1] = 4'hC; exp_t[2] = 4'h9; exp_t[3] = 4'h9; exp_t[4] = 4'h9;
      exp_t[5] = 4'hB;
      exp_c[0] = 8'h06; exp_c[1] = 8'h02; exp_c[2] = 8'h05; exp_c[3] = 8'h05; exp_c[4] = 8'h05;
      exp_c[5] = 8'h03;
      stat_base = rdsr_total; stat_w = 32'h00000303; rd_val = 8'h3C;
      n0 = n_cmds;
      do_req(2'd2, 24'h000100, 8'h3C, d, e, lat, rcyc, seen, one);
`ifdef FLASH_VERIFY_EN
      w = 6;
`else
      w = 5;
`endif
      chk("pp chain count", 32'(n_cmds - n0), 32'(w));
      for (int i = 0; i < w; i++) begin
         chk($sformatf("pp chain type%0d", i), 32'(log_type[(n0 + i) % 128]), 32'(exp_t[i]));
         chk($sformatf("pp chain cmd%0d", i), 32'(log_cmd[(n0 + i) % 128]), 32'(exp_c[i]));
      end
      for (int i = 0; i < w - 1; i++)
         chk($sformatf("pp gap%0d", i),
             32'(log_start[(n0 + i + 1) % 128] - log_done[(n0 + i) % 128]), 32'(CMD_GAP + 1));
      chk("pp addr", 32'(log_addr[(n0 + 1) % 128]), 32'h000100);
      chk("pp wrdata", 32'(log_wr[(n0 + 1) % 128]), 32'h3C);
      chk("pp latency", 32'(rcyc - log_done[(n0 + w - 1) % 128]), 32'(CMD_GAP + 1));
      chk("pp err", 32'(e), 32'd0);

      // Reset while PP is in flight
      eng_stall = 1'b1; stat_base = rdsr_total; stat_w = 32'h0;
      n0 = n_cmds; r0 = rsp_cnt;
      ifc.req_valid = 1'b1; ifc.req_op = 2'd2; ifc.req_addr = 24'h000200; ifc.req_wdata = 8'h99;
      @(negedge clk);
      ifc.req_valid = 1'b0;
      w = 0;
      while (!(n_cmds - n0 >= 2 && ifc.cmd_type == 4'hC) && w < 200) begin @(negedge clk); w++; end
      chk("pp in flight", 32'(ifc.cmd_type), 32'hC);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst mid pp cmd_type", 32'(ifc.cmd_type), 32'd0);
      chk("rst mid pp busy", 32'(ifc.busy), 32'd0);
      chk("rst mid pp rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      rst = 1'b0; eng_stall = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst mid pp no rsp", 32'(rsp_cnt - r0), 32'd0);
      chk("rst mid pp idle cmd", 32'(ifc.cmd_type), 32'd0);

      rd_val = 8'h7E; n0 = n_cmds;
      do_req(2'd0, 24'h000042, 8'h00, d, e, lat, rcyc, seen, one);
      chk("post rst read seen", 32'(seen), 32'd1);
      chk("post rst read data", 32'(d), 32'h7E);
      chk("post rst read err", 32'(e), 32'd0);
      chk("post rst read cmds", 32'(n_cmds - n0), 32'd1);

      chk("engine outputs held", 32'(hold_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
